// File: rtl/upsampler_h_zero_stuff_window_fp16_if.sv
// Stream interface for the fp16 zero-stuffing window front end: raster pixel input
// with ready/valid handshake, 1x7 window output with column/row tags.
interface upsampler_h_zero_stuff_window_fp16_if #(
    parameter int FP_WIDTH_REG = 16,
    parameter int WINDOW_WIDTH = 7
);
    logic [FP_WIDTH_REG-1:0]                        data_i;
    logic [15:0]                                    col_i;
    logic [15:0]                                    row_i;
    logic                                           valid_i;
    logic                                           ready_o;
    logic [0:0][WINDOW_WIDTH-1:0][FP_WIDTH_REG-1:0] window_o;
    logic [15:0]                                    col_o;
    logic [15:0]                                    row_o;
    logic                                           valid_o;
    logic                                           sync_err_o;

    modport master (
        output data_i, col_i, row_i, valid_i,
        input  ready_o, window_o, col_o, row_o, valid_o, sync_err_o
    );

    modport slave (
        input  data_i, col_i, row_i, valid_i,
        output ready_o, window_o, col_o, row_o, valid_o, sync_err_o
    );
endinterface

// File: rtl/upsampler_h_zero_stuff_window_fp16.sv
// Zero-stuffs a raster fp16 stream (z[2c]=x[c], z[2c+1]=0) and emits one 1x7 window of z
// per output column, throttling the input to one pixel every two clocks.
//
// state | meaning
// IDLE  | waiting for column 0 of a new row
// ODD   | shifting in the stuffed zero after an accepted pixel
// EVEN  | waiting for the next expected column
// FLUSH | shifting in the three right-pad zeros at end of row
module upsampler_h_zero_stuff_window_fp16 #(
    parameter int EXP_WIDTH    = 5,
    parameter int FRAC_WIDTH   = 10,
    parameter int WINDOW_WIDTH = 7,
    parameter int IMG_WIDTH    = 320
) (
    input logic                                  clk_i,
    input logic                                  rst_i,
    upsampler_h_zero_stuff_window_fp16_if.slave  bus
);
    localparam int          FP_WIDTH_REG = 1 + EXP_WIDTH + FRAC_WIDTH;
    localparam int          HALF         = WINDOW_WIDTH / 2;
    localparam logic [15:0] HALF_IDX     = 16'(HALF);
    localparam logic [15:0] LAST_COL     = 16'(IMG_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, ODD, EVEN, FLUSH} state_t;
    typedef logic [WINDOW_WIDTH-1:0][FP_WIDTH_REG-1:0] taps_t;

    state_t      state;
    taps_t       taps;
    taps_t       taps_zero;
    taps_t       taps_data;
    taps_t       taps_restart;
    taps_t       step_taps;
    logic [15:0] s_idx;
    logic [15:0] s_next;
    logic [15:0] last_col;
    logic [15:0] exp_col;
    logic [1:0]  flush_cnt;
    logic        col_match;
    logic        col_zero;
    logic        step_en;

    always_comb begin
        s_next       = s_idx + 16'd1;
        exp_col      = last_col + 16'd1;
        taps_zero    = {{FP_WIDTH_REG{1'b0}}, taps[WINDOW_WIDTH-1:1]};
        taps_data    = {bus.data_i, taps[WINDOW_WIDTH-1:1]};
        taps_restart = '0;
        taps_restart[WINDOW_WIDTH-1] = bus.data_i;
        col_match    = (bus.col_i == exp_col);
        col_zero     = (bus.col_i == 16'd0);
        step_en      = (state == ODD) || (state == FLUSH) ||
                       ((state == EVEN) && bus.valid_i && col_match);
        step_taps    = (state == EVEN) ? taps_data : taps_zero;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state          <= IDLE;
            taps           <= '0;
            s_idx          <= '0;
            last_col       <= '0;
            flush_cnt      <= '0;
            bus.ready_o    <= 1'b0;
            bus.window_o   <= '0;
            bus.col_o      <= '0;
            bus.row_o      <= '0;
            bus.valid_o    <= 1'b0;
            bus.sync_err_o <= 1'b0;
        end else begin
            bus.valid_o    <= 1'b0;
            bus.sync_err_o <= 1'b0;

            // Window k is complete once z[k+3] is in tap 6, i.e. stuffed index s = k+3.
            if (step_en) begin
                taps  <= step_taps;
                s_idx <= s_next;
                if (s_next >= HALF_IDX) begin
                    bus.valid_o     <= 1'b1;
                    bus.col_o       <= s_next - HALF_IDX;
                    bus.window_o[0] <= step_taps;
                end
            end

            case (state)
                IDLE: begin
                    bus.ready_o <= 1'b1;
                    if (bus.ready_o && bus.valid_i) begin
                        if (col_zero) begin
                            taps        <= taps_restart;
                            s_idx       <= '0;
                            last_col    <= '0;
                            bus.row_o   <= bus.row_i;
                            state       <= ODD;
                            bus.ready_o <= 1'b0;
                        end else begin
                            bus.sync_err_o <= 1'b1;
                        end
                    end
                end
                ODD: begin
                    if (last_col == LAST_COL) begin
                        state       <= FLUSH;
                        flush_cnt   <= '0;
                        bus.ready_o <= 1'b0;
                    end else begin
                        state       <= EVEN;
                        bus.ready_o <= 1'b1;
                    end
                end
                EVEN: begin
                    if (bus.valid_i) begin
                        if (col_match) begin
                            last_col    <= bus.col_i;
                            state       <= ODD;
                            bus.ready_o <= 1'b0;
                        end else if (col_zero) begin
                            // Early row start: abandon the partial row and begin afresh.
                            taps           <= taps_restart;
                            s_idx          <= '0;
                            last_col       <= '0;
                            bus.row_o      <= bus.row_i;
                            state          <= ODD;
                            bus.ready_o    <= 1'b0;
                            bus.sync_err_o <= 1'b1;
                        end else begin
                            bus.sync_err_o <= 1'b1;
                        end
                    end
                end
                FLUSH: begin
                    flush_cnt <= flush_cnt + 2'd1;
                    if (flush_cnt == 2'd2) begin
                        state       <= IDLE;
                        bus.ready_o <= 1'b1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    bus.ready_o <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_upsampler_h_zero_stuff_window_fp16.sv
// Self-checking bench: a row-level zero-stuffing model predicts every window, its cycle and
// every sync error; directed rows plus randomized rows drive the handshake.
module tb_upsampler_h_zero_stuff_window_fp16;
    localparam int W  = 4;
    localparam int FP = 16;
    localparam int NT = 7;
    localparam int HF = 3;

    typedef logic [NT-1:0][FP-1:0] win_t;
    typedef struct {
        int   due;
        int   col;
        int   row;
        win_t win;
    } exp_t;

    logic clk_i = 1'b0;
    logic rst_i = 1'b0;
    always #5 clk_i = ~clk_i;

    upsampler_h_zero_stuff_window_fp16_if #(.FP_WIDTH_REG(FP), .WINDOW_WIDTH(NT)) bus();

    upsampler_h_zero_stuff_window_fp16 #(
        .EXP_WIDTH(5), .FRAC_WIDTH(10), .WINDOW_WIDTH(NT), .IMG_WIDTH(W)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .bus(bus)
    );

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    exp_t exp_q[$];
    int   err_q[$];
    bit   in_row;
    int   exp_col;
    int   cur_row;
    int   n_known;
    logic [FP-1:0] xs [W];

    win_t seen_win [2*W];
    int   seen_cyc [2*W];
    int   rows_k0[$];
    int   win_count;
    int   err_seen;
    bit   ready_log [int];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
        compared++;
        if (act !== expv) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic win_t mk7(input logic [FP-1:0] a0, a1, a2, a3, a4, a5, a6);
        win_t w;
        w[0] = a0; w[1] = a1; w[2] = a2; w[3] = a3; w[4] = a4; w[5] = a5; w[6] = a6;
        return w;
    endfunction

    // Stuffed sequence of the current row; anything outside the known pixels is zero pad.
    function automatic logic [FP-1:0] zval(input int i);
        if (i < 0 || (i % 2) != 0) return '0;
        if (i / 2 >= n_known) return '0;
        return xs[i/2];
    endfunction

    function automatic win_t window_at(input int k);
        win_t w;
        for (int j = 0; j < NT; j++) w[j] = zval(k - HF + j);
        return w;
    endfunction

    function automatic void push_win(input int k, input int due);
        exp_t e;
        if (k < 0) return;
        e.due = due; e.col = k; e.row = cur_row; e.win = window_at(k);
        exp_q.push_back(e);
    endfunction

    function automatic void start_row(input int r, input logic [FP-1:0] d);
        xs[0] = d; n_known = 1; exp_col = 1; in_row = 1'b1; cur_row = r;
    endfunction

    // Pixel c completes windows 2c-3 (on the accept edge) and 2c-2 (one edge later).
    function automatic void model_accept(input int c, input int r, input logic [FP-1:0] d, input int t);
        if (in_row && c == exp_col) begin
            xs[c] = d; n_known++; exp_col++;
            push_win(2*c - 3, t);
            push_win(2*c - 2, t + 1);
            if (c == W - 1) begin
                for (int i = 0; i < 3; i++) push_win(2*W - 3 + i, t + 2 + i);
                in_row = 1'b0;
            end
        end else if (c == 0) begin
            if (in_row) err_q.push_back(t);
            start_row(r, d);
        end else begin
            err_q.push_back(t);
        end
    endfunction

    exp_t cmp_e;
    bit   cmp_ee;
    always @(negedge clk_i) begin
        if (rst_i) begin
            ready_log[cyc] = bus.ready_o;
            if (bus.valid_o) begin
                win_count++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_window", bus.valid_o, 1'b0);
                end else begin
                    cmp_e = exp_q.pop_front();
                    chk("win_cycle", cyc, cmp_e.due);
                    chk("win_col", bus.col_o, cmp_e.col);
                    chk("win_row", bus.row_o, cmp_e.row);
                    chk("win_data", bus.window_o[0], cmp_e.win);
                end
                if (bus.col_o < 16'(2*W)) begin
                    seen_win[bus.col_o] = bus.window_o[0];
                    seen_cyc[bus.col_o] = cyc;
                end
                if (bus.col_o == 16'd0) rows_k0.push_back(int'(bus.row_o));
            end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                cmp_e = exp_q.pop_front();
                chk("missing_window", bus.valid_o, 1'b1);
            end
            cmp_ee = 1'b0;
            if (err_q.size() > 0 && err_q[0] <= cyc) begin
                cmp_ee = 1'b1;
                void'(err_q.pop_front());
            end
            if (bus.sync_err_o) err_seen++;
            chk("sync_err", bus.sync_err_o, cmp_ee);
        end
    end

    task automatic send(input int c, input int r, input logic [FP-1:0] d, output int t);
        bit acc = 1'b0;
        int n   = 0;
        t = -1;
        while (!acc && n < 40) begin
            @(negedge clk_i);
            bus.valid_i = 1'b1;
            bus.col_i   = 16'(c);
            bus.row_i   = 16'(r);
            bus.data_i  = d;
            if (bus.ready_o) begin
                t = cyc + 1;
                model_accept(c, r, d, t);
                acc = 1'b1;
            end
            @(posedge clk_i);
            n++;
        end
        if (!acc) chk("send_timeout", acc, 1'b1);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk_i);
            bus.valid_i = 1'b0;
            @(posedge clk_i);
        end
    endtask

    task automatic drain();
        int n = 0;
        @(negedge clk_i);
        bus.valid_i = 1'b0;
        while ((exp_q.size() > 0 || err_q.size() > 0) && n < 60) begin
            @(negedge clk_i);
            n++;
        end
        chk("drain_timeout", exp_q.size() + err_q.size(), 0);
        repeat (3) @(negedge clk_i);
    endtask

    int t0, t1, td, e0;
    logic [FP-1:0] rd;
    int pat [11] = '{0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 1};

    initial begin
        bus.valid_i = 1'b0; bus.col_i = '0; bus.row_i = '0; bus.data_i = '0;
        in_row = 1'b0; exp_col = 0; cur_row = 0; n_known = 0;
        win_count = 0; err_seen = 0;
        #1;
        chk("reset_ready", bus.ready_o, 1'b0);
        chk("reset_valid", bus.valid_o, 1'b0);
        chk("reset_window", bus.window_o[0], '0);
        repeat (3) @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        chk("idle_ready", bus.ready_o, 1'b1);

        // 1: clean row, valid held high
        win_count = 0;
        send(0, 1, 16'h3C00, t0);
        send(1, 1, 16'h4000, td);
        send(2, 1, 16'h4200, td);
        send(3, 1, 16'h4400, td);
        drain();
        chk("t1_win_count", win_count, 8);
        chk("t1_k0", seen_win[0], mk7(16'h0, 16'h0, 16'h0, 16'h3C00, 16'h0, 16'h4000, 16'h0));
        chk("t1_k7", seen_win[7], mk7(16'h4200, 16'h0, 16'h4400, 16'h0, 16'h0, 16'h0, 16'h0));
        for (int i = 0; i < 11; i++)
            chk($sformatf("t1_ready_%0d", i), ready_log.exists(t0 + i) ? ready_log[t0 + i] : 1'bx, pat[i]);

        // 2: stall of three EVEN cycles before col 2
        win_count = 0;
        send(0, 2, 16'h3C00, td);
        send(1, 2, 16'h4000, t1);
        idle(4);
        send(2, 2, 16'h4200, td);
        send(3, 2, 16'h4400, td);
        drain();
        chk("t2_win_count", win_count, 8);
        chk("t2_gap", seen_cyc[1] - seen_cyc[0], 4);
        chk("t2_k0", seen_win[0], mk7(16'h0, 16'h0, 16'h0, 16'h3C00, 16'h0, 16'h4000, 16'h0));
        chk("t2_k7", seen_win[7], mk7(16'h4200, 16'h0, 16'h4400, 16'h0, 16'h0, 16'h0, 16'h0));

        // 3: rows 5 and 6 back to back
        for (int c = 0; c < W; c++) send(c, 5, 16'h5000 + 16'(c), td);
        for (int c = 0; c < W; c++) send(c, 6, 16'h6000 + 16'(c), td);
        drain();
        chk("t3_row5", rows_k0[rows_k0.size()-2], 5);
        chk("t3_row6", rows_k0[rows_k0.size()-1], 6);
        chk("t3_left_pad", seen_win[0][2:0], '0);

        // 4: early row start
        win_count = 0;
        e0 = err_seen;
        send(0, 7, 16'h1111, td);
        send(1, 7, 16'h2222, td);
        send(0, 8, 16'h3333, td);
        send(1, 8, 16'h4444, td);
        send(2, 8, 16'h5555, td);
        send(3, 8, 16'h6666, td);
        drain();
        chk("t4_err_count", err_seen - e0, 1);
        chk("t4_win_count", win_count, 9);
        chk("t4_k0", seen_win[0], mk7(16'h0, 16'h0, 16'h0, 16'h3333, 16'h0, 16'h4444, 16'h0));

        // 5: out-of-order column dropped
        e0 = err_seen;
        send(0, 9, 16'h0A00, td);
        send(1, 9, 16'h0B00, td);
        send(3, 9, 16'h0D00, td);
        @(negedge clk_i);
        bus.valid_i = 1'b0;
        chk("t5_ready_after_drop", bus.ready_o, 1'b1);
        send(2, 9, 16'h0C00, td);
        send(3, 9, 16'h0D00, td);
        drain();
        chk("t5_err_count", err_seen - e0, 1);

        // 6: reset during ODD of col 1
        send(0, 10, 16'h7000, td);
        send(1, 10, 16'h7100, td);
        #2;
        rst_i = 1'b0;
        exp_q.delete(); err_q.delete(); in_row = 1'b0;
        #1;
        chk("t6_ready", bus.ready_o, 1'b0);
        chk("t6_valid", bus.valid_o, 1'b0);
        chk("t6_sync_err", bus.sync_err_o, 1'b0);
        chk("t6_col", bus.col_o, '0);
        chk("t6_row", bus.row_o, '0);
        chk("t6_window", bus.window_o[0], '0);
        bus.valid_i = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        chk("t6_ready_after_release", bus.ready_o, 1'b1);
        win_count = 0;
        for (int c = 0; c < W; c++) send(c, 11, 16'h7800 + 16'(c), td);
        drain();
        chk("t6_win_count", win_count, 8);

        // random rows with stalls and occasional bad columns
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < W; c++) begin
                int g;
                g = $urandom_range(0, 2);
                if (g > 0) idle(g);
                if ($urandom_range(0, 9) == 0) begin
                    rd = 16'($urandom);
                    send(c + 2, 20 + r, rd, td);
                end
                rd = 16'($urandom);
                send(c, 20 + r, rd, td);
            end
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
